mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/computer_pkg.sv | 14 +
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/computer_pkg.sv
// Shared definitions for the computer memory subsystem: bus width defaults and
// the access-owner encoding used by the arbiter, address decode and video blocks.
package computer_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_VID  = 2'd2
   } own_e;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the CPU (read/write) and video (read-only).
// CPU has priority unless video has been denied MAX_WAIT cycles in a row.
module mem_arbiter
   import computer_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_WAIT = 3
) (
   input  logic              clk,
   input  logic              res,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_adr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_adr,
   output logic              vid_gnt,
   output logic [DATA_W-1:0] vid_rdata,
   output logic              vid_rvalid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CPU   = 2'd1;
   localparam logic [1:0] ST_VID   = 2'd2;
   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v >= WAIT_MAX) ? WAIT_MAX : v + 4'd1;
   endfunction

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [3:0]        r_wait;
   own_e              w_tag_nxt;
   own_e              r_tag_p1;
   logic              r_mem_en_p1;
   logic              r_mem_we_p1;
   logic [ADDR_W-1:0] r_mem_adr_p1;
   logic [DATA_W-1:0] r_mem_wdata_p1;
   logic              r_cpu_rvalid_p2;
   logic              r_vid_rvalid_p2;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_vid_rdata;

   always_comb begin
      w_state_nxt = ST_IDLE;
      if (cpu_req && vid_req)
         w_state_nxt = (r_wait == WAIT_MAX) ? ST_VID : ST_CPU;
      else if (cpu_req)
         w_state_nxt = ST_CPU;
      else if (vid_req)
         w_state_nxt = ST_VID;
   end

   // Only reads are tagged, so a CPU write never produces a return pulse.
   always_comb begin
      w_tag_nxt = OWN_NONE;
      if (w_state_nxt == ST_CPU && !cpu_we)
         w_tag_nxt = OWN_CPU;
      else if (w_state_nxt == ST_VID)
         w_tag_nxt = OWN_VID;
   end

   // Stage p1: access issue to RAM
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         r_state        <= ST_IDLE;
         r_wait         <= '0;
         r_tag_p1       <= OWN_NONE;
         r_mem_en_p1    <= 1'b0;
         r_mem_we_p1    <= 1'b0;
         r_mem_adr_p1   <= '0;
         r_mem_wdata_p1 <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_tag_p1    <= w_tag_nxt;
         r_mem_en_p1 <= (w_state_nxt != ST_IDLE);
         r_mem_we_p1 <= (w_state_nxt == ST_CPU) && cpu_we;
         if (w_state_nxt == ST_CPU) begin
            r_mem_adr_p1   <= cpu_adr;
            r_mem_wdata_p1 <= cpu_wdata;
         end else if (w_state_nxt == ST_VID) begin
            r_mem_adr_p1   <= vid_adr;
         end
         r_wait <= (vid_req && w_state_nxt != ST_VID) ? sat_inc(r_wait) : 4'd0;
      end
   end

   // Stage p2: read return, routed by the tag issued with the access
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         r_cpu_rvalid_p2 <= 1'b0;
         r_vid_rvalid_p2 <= 1'b0;
         r_cpu_rdata     <= '0;
         r_vid_rdata     <= '0;
      end else begin
         r_cpu_rvalid_p2 <= (r_tag_p1 == OWN_CPU);
         r_vid_rvalid_p2 <= (r_tag_p1 == OWN_VID);
         r_cpu_rdata     <= cpu_rdata;
         r_vid_rdata     <= vid_rdata;
      end
   end

   assign cpu_gnt    = (r_state == ST_CPU);
   assign vid_gnt    = (r_state == ST_VID);
   assign mem_en     = r_mem_en_p1;
   assign mem_we     = r_mem_we_p1;
   assign mem_adr    = r_mem_adr_p1;
   assign mem_wdata  = r_mem_wdata_p1;
   assign cpu_rvalid = r_cpu_rvalid_p2;
   assign vid_rvalid = r_vid_rvalid_p2;
   assign cpu_rdata  = r_cpu_rvalid_p2 ? mem_rdata : r_cpu_rdata;
   assign vid_rdata  = r_vid_rvalid_p2 ? mem_rdata : r_vid_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-read RAM model attached.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        res;
   logic        cpu_req, cpu_we;
   logic [15:0] cpu_adr;
   logic [7:0]  cpu_wdata;
   logic        cpu_gnt, cpu_rvalid;
   logic [7:0]  cpu_rdata;
   logic        vid_req;
   logic [15:0] vid_adr;
   logic        vid_gnt, vid_rvalid;
   logic [7:0]  vid_rdata;
   logic        mem_en, mem_we;
   logic [15:0] mem_adr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   logic        pre_we;
   logic [15:0] pre_adr;
   logic [7:0]  pre_dat;
   logic [7:0]  ram [0:65535];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_WAIT(3)) dut (
      .clk(clk), .res(res),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .vid_req(vid_req), .vid_adr(vid_adr),
      .vid_gnt(vid_gnt), .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // RAM model: synchronous write, registered read, plus a bench preload port
   always @(posedge clk) begin
      if (pre_we) ram[pre_adr] <= pre_dat;
      if (mem_en && mem_we) ram[mem_adr] <= mem_wdata;
      if (mem_en) mem_rdata <= ram[mem_adr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [15:0] a, input logic [7:0] d);
      pre_we  = 1'b1;
      pre_adr = a;
      pre_dat = d;
      tick();
      pre_we  = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".cpu_gnt"},    {31'd0, cpu_gnt},    32'd0);
      chk({tag, ".vid_gnt"},    {31'd0, vid_gnt},    32'd0);
      chk({tag, ".cpu_rvalid"}, {31'd0, cpu_rvalid}, 32'd0);
      chk({tag, ".vid_rvalid"}, {31'd0, vid_rvalid}, 32'd0);
      chk({tag, ".mem_en"},     {31'd0, mem_en},     32'd0);
      chk({tag, ".mem_we"},     {31'd0, mem_we},     32'd0);
      chk({tag, ".mem_adr"},    {16'd0, mem_adr},    32'd0);
      chk({tag, ".mem_wdata"},  {24'd0, mem_wdata},  32'd0);
      chk({tag, ".cpu_rdata"},  {24'd0, cpu_rdata},  32'd0);
      chk({tag, ".vid_rdata"},  {24'd0, vid_rdata},  32'd0);
   endtask

   initial begin
      int own, prev;
      logic [7:0] vid_pat;
      res = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
      vid_req = 1'b0; vid_adr = '0;
      pre_we = 1'b0; pre_adr = '0; pre_dat = '0;
      #1;
      chk_all_zero("reset");

      preload(16'h0200, 8'hA5);
      preload(16'h0300, 8'h22);
      preload(16'h4000, 8'h11);
      chk_all_zero("reset_held");
      res = 1'b0;

      // CPU read
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0200;
      tick();
      chk("rd.cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
      chk("rd.mem_en",  {31'd0, mem_en},  32'd1);
      chk("rd.mem_we",  {31'd0, mem_we},  32'd0);
      chk("rd.mem_adr", {16'd0, mem_adr}, 32'h0200);
      chk("rd.vid_gnt", {31'd0, vid_gnt}, 32'd0);
      cpu_req = 1'b0;
      tick();
      chk("rd.cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
      chk("rd.cpu_rdata",  {24'd0, cpu_rdata},  32'hA5);
      chk("rd.vid_rvalid", {31'd0, vid_rvalid}, 32'd0);
      chk("rd.idle_en",    {31'd0, mem_en},     32'd0);

      // CPU write
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 16'h0010; cpu_wdata = 8'h3C;
      tick();
      chk("wr.cpu_gnt",   {31'd0, cpu_gnt},   32'd1);
      chk("wr.mem_en",    {31'd0, mem_en},    32'd1);
      chk("wr.mem_we",    {31'd0, mem_we},    32'd1);
      chk("wr.mem_adr",   {16'd0, mem_adr},   32'h0010);
      chk("wr.mem_wdata", {24'd0, mem_wdata}, 32'h3C);
      cpu_req = 1'b0; cpu_we = 1'b0;
      tick();
      chk("wr.cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      chk("wr.vid_rvalid", {31'd0, vid_rvalid}, 32'd0);
      chk("wr.mem_we_off", {31'd0, mem_we},     32'd0);
      chk("wr.mem_en_off", {31'd0, mem_en},     32'd0);
      chk("wr.adr_hold",   {16'd0, mem_adr},    32'h0010);
      chk("wr.wdata_hold", {24'd0, mem_wdata},  32'h3C);

      // Read back the written location
      cpu_req = 1'b1; cpu_adr = 16'h0010;
      tick();
      cpu_req = 1'b0;
      tick();
      chk("wrrb.cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
      chk("wrrb.cpu_rdata",  {24'd0, cpu_rdata},  32'h3C);

      // Both held: video wins every 4th grant
      vid_pat = 8'b1000_1000;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0300;
      vid_req = 1'b1; vid_adr = 16'h4000;
      prev = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         own = vid_pat[i] ? 2 : 1;
         chk($sformatf("both%0d.cpu_gnt", i), {31'd0, cpu_gnt}, (own == 1) ? 32'd1 : 32'd0);
         chk($sformatf("both%0d.vid_gnt", i), {31'd0, vid_gnt}, (own == 2) ? 32'd1 : 32'd0);
         chk($sformatf("both%0d.mem_adr", i), {16'd0, mem_adr}, (own == 1) ? 32'h0300 : 32'h4000);
         chk($sformatf("both%0d.cpu_rvalid", i), {31'd0, cpu_rvalid}, (prev == 1) ? 32'd1 : 32'd0);
         chk($sformatf("both%0d.vid_rvalid", i), {31'd0, vid_rvalid}, (prev == 2) ? 32'd1 : 32'd0);
         if (prev == 1) chk($sformatf("both%0d.cpu_rdata", i), {24'd0, cpu_rdata}, 32'h22);
         if (prev == 2) chk($sformatf("both%0d.vid_rdata", i), {24'd0, vid_rdata}, 32'h11);
         prev = own;
      end
      cpu_req = 1'b0; vid_req = 1'b0;
      tick();
      chk("both_tail.vid_rvalid", {31'd0, vid_rvalid}, 32'd1);
      chk("both_tail.vid_rdata",  {24'd0, vid_rdata},  32'h11);
      chk("both_tail.cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      tick();

      // Alternate owners every cycle
      prev = 0;
      for (int i = 0; i < 6; i++) begin
         own = (i % 2 == 0) ? 2 : 1;
         vid_req = (own == 2);
         cpu_req = (own == 1);
         tick();
         chk($sformatf("alt%0d.cpu_gnt", i), {31'd0, cpu_gnt}, (own == 1) ? 32'd1 : 32'd0);
         chk($sformatf("alt%0d.vid_gnt", i), {31'd0, vid_gnt}, (own == 2) ? 32'd1 : 32'd0);
         chk($sformatf("alt%0d.cpu_rvalid", i), {31'd0, cpu_rvalid}, (prev == 1) ? 32'd1 : 32'd0);
         chk($sformatf("alt%0d.vid_rvalid", i), {31'd0, vid_rvalid}, (prev == 2) ? 32'd1 : 32'd0);
         if (prev == 1) chk($sformatf("alt%0d.cpu_rdata", i), {24'd0, cpu_rdata}, 32'h22);
         if (prev == 2) chk($sformatf("alt%0d.vid_rdata", i), {24'd0, vid_rdata}, 32'h11);
         prev = own;
      end
      cpu_req = 1'b0; vid_req = 1'b0;
      tick();
      chk("alt_tail.cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
      chk("alt_tail.cpu_rdata",  {24'd0, cpu_rdata},  32'h22);
      chk("alt_tail.vid_rvalid", {31'd0, vid_rvalid}, 32'd0);
      tick();

      // Reset in the cycle a read is granted
      cpu_req = 1'b1; cpu_adr = 16'h0200;
      tick();
      chk("rst.pre_gnt", {31'd0, cpu_gnt}, 32'd1);
      #2;
      res = 1'b1;
      cpu_req = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      tick();
      res = 1'b0;
      tick();
      chk("rst.no_rvalid_cpu", {31'd0, cpu_rvalid}, 32'd0);
      chk("rst.no_rvalid_vid", {31'd0, vid_rvalid}, 32'd0);
      chk("rst.no_gnt",        {31'd0, cpu_gnt},    32'd0);
      cpu_req = 1'b1; cpu_adr = 16'h0200;
      tick();
      chk("rst.regnt", {31'd0, cpu_gnt}, 32'd1);
      cpu_req = 1'b0;
      tick();
      chk("rst.rvalid", {31'd0, cpu_rvalid}, 32'd1);
      chk("rst.rdata",  {24'd0, cpu_rdata},  32'hA5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
